// File: rtl/and_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : and_seq_pkg
// Purpose  : Shared state encoding and width helper for the serial AND
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package and_seq_pkg;

   // Sequencer states; two bits cover the three states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Width needed to hold any count from 0 to n inclusive.
   function automatic int lw_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/two_input_and.sv
`default_nettype none
// ============================================================================
// Module   : two_input_and
// Purpose  : Shared two-input AND unit used by the serial reduction step.
// Revision : 1.0 - initial release
// ============================================================================
module two_input_and (
   input  logic a,
   input  logic b,
   output logic y
);

   assign y = a & b;

endmodule
`default_nettype wire

// File: rtl/serial_and_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : serial_and_sequencer
// Purpose  : Reduces the low in_len bits of an operand with AND, one bit per
//            cycle through a single two-input AND unit, with optional early
//            exit on the first zero bit and a valid/ready result handshake.
// Revision : 1.0 - initial release
// ============================================================================
module serial_and_sequencer
   import and_seq_pkg::*;
#(
   parameter int  N          = 8,
   parameter int  EARLY_EXIT = 1,
   localparam int LW         = lw_width(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   input  logic [LW-1:0] in_len,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_y,
   output logic [LW-1:0] out_steps,
   output logic          busy
);

   localparam logic [LW-1:0] c_len_max = LW'(N);
   localparam logic [LW-1:0] c_one     = LW'(1);
   localparam logic [N-1:0]  c_bit0    = {{(N-1){1'b0}}, 1'b1};

   state_t        state_q, state_d;
   logic [N-1:0]  data_q,  data_d;
   logic [LW-1:0] len_q,   len_d;
   logic [LW-1:0] idx_q,   idx_d;
   logic [LW-1:0] steps_q, steps_d;
   logic          acc_q,   acc_d;

   logic [LW-1:0] w_len_clamped;
   logic [LW-1:0] w_idx_inc;
   logic [N-1:0]  w_sel;
   logic          w_bit;
   logic          w_and_y;
   logic          w_last;

   // Lengths beyond the operand width reduce the whole operand.
   assign w_len_clamped = (in_len > c_len_max) ? c_len_max : in_len;

   // Current operand bit picked with a one-hot mask so idx never indexes
   // past the operand.
   assign w_sel     = c_bit0 << idx_q;
   assign w_bit     = |(data_q & w_sel);
   assign w_idx_inc = idx_q + c_one;
   assign w_last    = (w_idx_inc == len_q);

   two_input_and u_and (
      .a (acc_q),
      .b (w_bit),
      .y (w_and_y)
   );

   // Next-state and datapath update for accept, reduce and result hand-off.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      len_d   = len_q;
      idx_d   = idx_q;
      steps_d = steps_q;
      acc_d   = acc_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               data_d  = in_data;
               len_d   = w_len_clamped;
               acc_d   = 1'b1;
               idx_d   = '0;
               steps_d = '0;
               state_d = (w_len_clamped == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            acc_d   = w_and_y;
            idx_d   = w_idx_inc;
            steps_d = steps_q + c_one;
            if (w_last || ((EARLY_EXIT != 0) && !w_and_y)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         steps_q <= '0;
         acc_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         steps_q <= steps_d;
         acc_q   <= acc_d;
      end
   end

   // in_ready is gated by rst_n so it reads low while reset is held.
   assign in_ready  = (state_q == ST_IDLE) && rst_n;
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign out_y     = (state_q == ST_DONE) && acc_q;
   assign out_steps = steps_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_and_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_serial_and_sequencer
// Purpose  : Self-checking bench; two instances (EARLY_EXIT=0 and =1) share
//            inputs and are compared each cycle against a transaction-level
//            model, plus directed literal cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_and_sequencer;

   localparam int N  = 8;
   localparam int LW = 4;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          in_valid  = 1'b0;
   logic          out_ready = 1'b0;
   logic [N-1:0]  in_data   = '0;
   logic [LW-1:0] in_len    = '0;

   logic [1:0]          in_ready_v;
   logic [1:0]          out_valid_v;
   logic [1:0]          out_y_v;
   logic [1:0]          busy_v;
   logic [1:0][LW-1:0]  out_steps_v;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_and_sequencer #(.N(N), .EARLY_EXIT(0)) u_dut_ee0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[0]),
      .in_data   (in_data),
      .in_len    (in_len),
      .out_valid (out_valid_v[0]),
      .out_ready (out_ready),
      .out_y     (out_y_v[0]),
      .out_steps (out_steps_v[0]),
      .busy      (busy_v[0])
   );

   serial_and_sequencer #(.N(N), .EARLY_EXIT(1)) u_dut_ee1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[1]),
      .in_data   (in_data),
      .in_len    (in_len),
      .out_valid (out_valid_v[1]),
      .out_ready (out_ready),
      .out_y     (out_y_v[1]),
      .out_steps (out_steps_v[1]),
      .busy      (busy_v[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Result of reducing one operand: AND of the low len bits, number of
   // AND steps, and cycles from accept to out_valid.
   function automatic void ref_model(input logic [N-1:0] d, input logic [LW-1:0] l,
                                     input bit ee, output bit y, output int st,
                                     output int lat);
      int           len;
      logic [N-1:0] mask;
      len  = (int'(l) > N) ? N : int'(l);
      mask = (len == 0) ? '0 : (~'0 >> (N - len));
      y    = ((d & mask) == mask);
      st   = len;
      if (ee && !y) begin
         for (int i = len - 1; i >= 0; i--) begin
            if (!d[i]) st = i + 1;
         end
      end
      lat = st + 1;
   endfunction

   // Transaction-level model per instance.
   bit m_busy [2];
   int m_cnt  [2];
   int m_lat  [2];
   int m_st   [2];
   bit m_y    [2];
   bit mdl_y;
   int mdl_st, mdl_lat;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0;
            m_cnt[i]  = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!m_busy[i]) begin
               if (in_valid) begin
                  ref_model(in_data, in_len, (i == 1), mdl_y, mdl_st, mdl_lat);
                  m_y[i]    = mdl_y;
                  m_st[i]   = mdl_st;
                  m_lat[i]  = mdl_lat;
                  m_busy[i] = 1'b1;
                  m_cnt[i]  = 1;
               end
            end else if (m_cnt[i] >= m_lat[i]) begin
               if (out_ready) m_busy[i] = 1'b0;
            end else begin
               m_cnt[i]++;
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   logic ev;
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         ev = m_busy[i] && (m_cnt[i] >= m_lat[i]);
         check($sformatf("in_ready[%0d]", i), in_ready_v[i], !m_busy[i] && rst_n);
         check($sformatf("busy[%0d]", i), busy_v[i], m_busy[i]);
         check($sformatf("out_valid[%0d]", i), out_valid_v[i], ev);
         if (ev) begin
            check($sformatf("out_y[%0d]", i), out_y_v[i], m_y[i]);
            check($sformatf("out_steps[%0d]", i), out_steps_v[i], m_st[i]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (in_ready_v != 2'b11 && k < 100) begin
         step();
         k++;
      end
      check("idle_wait", in_ready_v, 2'b11);
   endtask

   // Offer one operand, then record per-instance latency and result.
   task automatic txn(input logic [N-1:0] d, input logic [LW-1:0] l,
                      output int lat0, output int lat1,
                      output logic y0, output logic y1,
                      output logic [LW-1:0] s0, output logic [LW-1:0] s1);
      out_ready = 1'b0;
      wait_idle();
      in_valid = 1'b1;
      in_data  = d;
      in_len   = l;
      step();
      in_valid = 1'b0;
      in_data  = N'($urandom);
      in_len   = LW'($urandom);
      lat0 = -1; lat1 = -1;
      y0 = 1'b0; y1 = 1'b0; s0 = '0; s1 = '0;
      for (int c = 1; c <= 40; c++) begin
         if (out_valid_v[0] && lat0 < 0) begin
            lat0 = c; y0 = out_y_v[0]; s0 = out_steps_v[0];
         end
         if (out_valid_v[1] && lat1 < 0) begin
            lat1 = c; y1 = out_y_v[1]; s1 = out_steps_v[1];
         end
         if (lat0 >= 0 && lat1 >= 0) break;
         step();
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic expect_res(input string tag, input int lat0, input int lat1,
                             input logic y0, input logic y1,
                             input logic [LW-1:0] s0, input logic [LW-1:0] s1,
                             input int el0, input int el1, input logic ey0,
                             input logic ey1, input int es0, input int es1);
      check({tag, "_lat0"}, lat0, el0);
      check({tag, "_lat1"}, lat1, el1);
      check({tag, "_y0"}, y0, ey0);
      check({tag, "_y1"}, y1, ey1);
      check({tag, "_steps0"}, s0, es0);
      check({tag, "_steps1"}, s1, es1);
   endtask

   initial begin
      int            lat0, lat1;
      logic          y0, y1;
      logic [LW-1:0] s0, s1;
      bit            ry;
      int            rst_, rlat;

      // Model pinned against hand-computed values.
      ref_model(8'hFB, 4'd8, 1'b1, ry, rst_, rlat);
      check("model_fb_ee_y", ry, 0);
      check("model_fb_ee_steps", rst_, 3);
      check("model_fb_ee_lat", rlat, 4);
      ref_model(8'hFF, 4'd12, 1'b0, ry, rst_, rlat);
      check("model_clamp_steps", rst_, 8);
      check("model_clamp_lat", rlat, 9);

      // Reset values.
      rst_n = 1'b0;
      repeat (2) step();
      check("rst_in_ready", in_ready_v, 2'b00);
      check("rst_out_valid", out_valid_v, 2'b00);
      check("rst_out_y", out_y_v, 2'b00);
      check("rst_out_steps", out_steps_v, 8'h00);
      check("rst_busy", busy_v, 2'b00);
      rst_n = 1'b1;
      #1;
      check("first_cycle_ready", in_ready_v, 2'b11);

      // Full-width all-ones.
      txn(8'hFF, 4'd8, lat0, lat1, y0, y1, s0, s1);
      expect_res("ff8", lat0, lat1, y0, y1, s0, s1, 9, 9, 1, 1, 8, 8);
      handshake();

      // Third bit zero: early exit only on instance 1.
      txn(8'hFB, 4'd8, lat0, lat1, y0, y1, s0, s1);
      expect_res("fb8", lat0, lat1, y0, y1, s0, s1, 9, 4, 0, 0, 8, 3);
      handshake();

      // Empty reduction.
      txn(8'hA5, 4'd0, lat0, lat1, y0, y1, s0, s1);
      expect_res("len0", lat0, lat1, y0, y1, s0, s1, 1, 1, 1, 1, 0, 0);
      handshake();

      // Length clamped to operand width.
      txn(8'hFF, 4'd12, lat0, lat1, y0, y1, s0, s1);
      expect_res("len12", lat0, lat1, y0, y1, s0, s1, 9, 9, 1, 1, 8, 8);
      handshake();

      // Consumer stalls with a new operand pending.
      txn(8'h0F, 4'd4, lat0, lat1, y0, y1, s0, s1);
      expect_res("hold", lat0, lat1, y0, y1, s0, s1, 5, 5, 1, 1, 4, 4);
      in_valid = 1'b1;
      in_data  = 8'h01;
      in_len   = 4'd1;
      for (int h = 0; h < 5; h++) begin
         step();
         check("hold_valid", out_valid_v, 2'b11);
         check("hold_in_ready", in_ready_v, 2'b00);
         check("hold_y", out_y_v, 2'b11);
         check("hold_steps", out_steps_v, 8'h44);
      end
      handshake();
      in_valid = 1'b1;
      check("pending_idle_ready", in_ready_v, 2'b11);
      check("pending_idle_busy", busy_v, 2'b00);
      step();
      in_valid = 1'b0;
      check("pending_accepted", busy_v, 2'b11);
      out_ready = 1'b1;
      repeat (4) step();
      out_ready = 1'b0;

      // Reset during RUN discards the operation.
      wait_idle();
      in_valid = 1'b1;
      in_data  = 8'hFF;
      in_len   = 4'd8;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      check("midrst_valid", out_valid_v, 2'b00);
      check("midrst_busy", busy_v, 2'b00);
      check("midrst_in_ready", in_ready_v, 2'b00);
      step();
      rst_n = 1'b1;
      #1;
      check("midrst_release_ready", in_ready_v, 2'b11);
      check("midrst_release_busy", busy_v, 2'b00);
      repeat (12) step();
      check("midrst_no_result", out_valid_v, 2'b00);

      // Randomized traffic, including occasional resets.
      for (int r = 0; r < 600; r++) begin
         in_valid  = ($urandom_range(0, 2) == 0);
         in_data   = N'($urandom);
         in_len    = LW'($urandom_range(0, 12));
         out_ready = ($urandom_range(0, 1) == 1);
         rst_n     = ($urandom_range(0, 79) != 0);
         step();
      end
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (20) step();
      check("drain_idle", in_ready_v, 2'b11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_and_sequencer.md
SERIAL_AND_SEQUENCER -- requirements
Module: serial_and_sequencer

Interface
REQ-001 SHALL have parameter: N, default 8, maximum operand bit count (2..32).
REQ-002 SHALL have parameter: EARLY_EXIT, default 1, 1 = stop reducing on the first zero bit.
REQ-003 SHALL define derived width LW = $clog2(N+1).
REQ-004 SHALL have one clock, with reset asynchronous and active-low:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
REQ-005 SHALL have these ports:
- in_valid  input  1  operand offered
- in_ready  output  1  sequencer can accept an operand
- in_data  input  N  operand bits, reduced LSB first
- in_len  input  LW  number of bits to reduce
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_y  output  1  AND-reduction of in_data[in_len-1:0]
- out_steps  output  LW  number of AND operations performed
- busy  output  1  high in any state other than IDLE

Function
REQ-006 SHALL implement FSM states IDLE, RUN, DONE.
REQ-007 In IDLE: in_ready=1, out_valid=0.
- Accept when in_valid=1; latch in_data, len = min(in_len, N), acc=1, idx=0, steps=0.
REQ-008 On accept with len==0: go directly to DONE with out_y=1 and out_steps=0 (empty-AND identity).
REQ-009 On accept with len>0: go to RUN.
REQ-010 Each RUN cycle: acc <= acc & data[idx] via the shared two-input AND unit; idx++; steps++.
REQ-011 RUN SHALL exit to DONE after the cycle that processes idx==len-1.
- Without early exit, RUN lasts exactly len cycles.
REQ-012 If EARLY_EXIT=1 and the AND result in a RUN cycle is 0: go to DONE after that cycle.
- steps counts that cycle.
REQ-013 Accept-to-out_valid latency: len+1 cycles (1 cycle for len==0), or fewer on early exit.
REQ-014 In DONE: out_valid=1; out_y and out_steps held stable until out_ready=1.
- On out_valid & out_ready: return to IDLE.
REQ-015 in_ready SHALL be 0 in RUN and DONE; no new operand is accepted before the result is consumed.
- No back-to-back accept in the same cycle as handshake-out; IDLE is always visited.
REQ-016 in_len>N SHALL be clamped to N; the clamped value is reflected in out_steps.
REQ-017 Changes on in_data/in_len while not accepting SHALL have no effect.
REQ-018 idx and steps SHALL never exceed len; no wrap-around.
REQ-019 out_y and out_steps SHALL be driven from registers only, with no combinational path from inputs.

Reset
REQ-020 rst_n low SHALL asynchronously force state=IDLE, acc=1, idx=0, steps=0, and outputs out_valid=0, out_y=0, out_steps=0, busy=0, in_ready=0.
REQ-021 The first cycle after rst_n deassertion SHALL present in_ready=1.
REQ-022 Reset mid-RUN or mid-DONE SHALL discard the operation; no result is emitted.

Structure
REQ-023 Shared package and_seq_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and the LW width function.
REQ-024 The AND step SHALL be one instance of the existing two_input_and sub-module (a=acc, b=data[idx]).
- Only the sequencing logic lives in this block.
REQ-025 Datapath registers: data, len, idx, acc, steps.

Verification (N=8)
REQ-026 EARLY_EXIT=0, data=8'hFF, len=8:
- out_valid 9 cycles after accept, out_y=1, out_steps=8.
REQ-027 EARLY_EXIT=1, data=8'hFB, len=8:
- out_y=0, out_steps=3, out_valid 4 cycles after accept.
REQ-028 len=0, any data:
- out_valid the cycle after accept, out_y=1, out_steps=0.
REQ-029 len=12, data=8'hFF:
- out_steps=8, out_y=1.
REQ-030 Hold out_ready=0 for 5 cycles in DONE:
- out_valid, out_y, out_steps stable; in_ready=0 throughout.
- A pending in_valid is accepted only after the return to IDLE.
REQ-031 Assert rst_n=0 at RUN cycle 3:
- out_valid=0 immediately, busy=0, in_ready=1 after release, no stale result.
